// File: rtl/airlock_sequencer.sv
// Airlock chamber sequencer: drives doors, pump and one shared countdown timer
// to move crew between habitat and vacuum, arbitrating arrive/leave round-robin.
module airlock_sequencer #(
    parameter int unsigned CW           = 4,
    parameter int unsigned EVAC_TICKS   = 8,
    parameter int unsigned PRESS_TICKS  = 7,
    parameter int unsigned SETTLE_TICKS = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          arrive_req,
    input  logic          leave_req,
    input  logic          occupied,
    input  logic          hold,
    output logic          grant_arrive,
    output logic          grant_leave,
    output logic          inner_port,
    output logic          outer_port,
    output logic          evacuating,
    output logic          pressurizing,
    output logic          settling,
    output logic          busy,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] EVAC_N     = CW'(EVAC_TICKS);
    localparam logic [CW-1:0] PRESS_N    = CW'(PRESS_TICKS);
    localparam logic [CW-1:0] SETTLE_N   = CW'(SETTLE_TICKS);
    localparam bit            HAS_SETTLE = (SETTLE_TICKS != 0);

    typedef enum logic [2:0] {
        IDLE,
        INNER_OPEN,
        OUTER_OPEN,
        SETTLE,
        EVAC,
        PRESS
    } state_t;

    state_t        state, state_nxt;
    logic          dir, dir_nxt;
    logic          phase, phase_nxt;
    logic          rr_leave, rr_leave_nxt;
    logic [CW-1:0] count_nxt;
    logic          grant_arrive_nxt, grant_leave_nxt;
    logic          timer_done;

    assign timer_done = (count == '0);

    // Next-state, arbitration and timer logic; hold freezes everything.
    always_comb begin
        state_nxt        = state;
        dir_nxt          = dir;
        phase_nxt        = phase;
        rr_leave_nxt     = rr_leave;
        grant_arrive_nxt = 1'b0;
        grant_leave_nxt  = 1'b0;
        count_nxt        = count;

        if (!hold) begin
            unique case (state)
                IDLE: begin
                    if (arrive_req && (!leave_req || !rr_leave)) begin
                        grant_arrive_nxt = 1'b1;
                        dir_nxt          = 1'b0;
                        phase_nxt        = 1'b0;
                        rr_leave_nxt     = 1'b1;
                        state_nxt        = EVAC;
                    end else if (leave_req) begin
                        grant_leave_nxt = 1'b1;
                        dir_nxt         = 1'b1;
                        phase_nxt       = 1'b0;
                        rr_leave_nxt    = 1'b0;
                        state_nxt       = INNER_OPEN;
                    end
                end
                EVAC: begin
                    if (timer_done) state_nxt = OUTER_OPEN;
                end
                // Arrive waits for the occupant to step in, leave for them to step out.
                OUTER_OPEN: begin
                    if (occupied != dir) begin
                        phase_nxt = 1'b1;
                        state_nxt = HAS_SETTLE ? SETTLE : PRESS;
                    end
                end
                INNER_OPEN: begin
                    if (occupied == dir) begin
                        if (!dir) state_nxt = IDLE;
                        else      state_nxt = HAS_SETTLE ? SETTLE : EVAC;
                    end
                end
                SETTLE: begin
                    if (timer_done) state_nxt = (dir && !phase) ? EVAC : PRESS;
                end
                PRESS: begin
                    if (timer_done) state_nxt = dir ? IDLE : INNER_OPEN;
                end
                default: state_nxt = IDLE;
            endcase

            if (state_nxt != state) begin
                unique case (state_nxt)
                    EVAC:    count_nxt = EVAC_N;
                    PRESS:   count_nxt = PRESS_N;
                    SETTLE:  count_nxt = SETTLE_N;
                    default: count_nxt = '0;
                endcase
            end else if (tick && !timer_done) begin
                count_nxt = count - CW'(1);
            end
        end
    end

    // State register with outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            dir          <= 1'b0;
            phase        <= 1'b0;
            rr_leave     <= 1'b0;
            count        <= '0;
            grant_arrive <= 1'b0;
            grant_leave  <= 1'b0;
            inner_port   <= 1'b0;
            outer_port   <= 1'b0;
            evacuating   <= 1'b0;
            pressurizing <= 1'b0;
            settling     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            dir          <= dir_nxt;
            phase        <= phase_nxt;
            rr_leave     <= rr_leave_nxt;
            count        <= count_nxt;
            grant_arrive <= grant_arrive_nxt;
            grant_leave  <= grant_leave_nxt;
            inner_port   <= (state_nxt == INNER_OPEN);
            outer_port   <= (state_nxt == OUTER_OPEN);
            evacuating   <= (state_nxt == EVAC);
            pressurizing <= (state_nxt == PRESS);
            settling     <= (state_nxt == SETTLE);
            busy         <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_airlock_sequencer.sv
// Scoreboard bench for airlock_sequencer: expected phase/grant events are queued by
// the stimulus and popped by per-DUT monitors that watch the registered outputs.
module tb_airlock_sequencer;

    localparam int unsigned CW = 4;
    localparam int C_IDLE = 0, C_EVAC = 3, C_OUTER = 4, C_SETTLE = 5, C_PRESS = 6, C_INNER = 7;
    localparam int C_GA = 8, C_GL = 9;

    typedef struct {
        int code;
        int cnt;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tick = 1'b0;
    logic arrive_req = 1'b0, leave_req = 1'b0, occupied = 1'b0, hold = 1'b0;
    logic grant_arrive, grant_leave, inner_port, outer_port, evacuating, pressurizing, settling, busy;
    logic [CW-1:0] count;

    logic arrive_req2 = 1'b0, leave_req2 = 1'b0;
    logic grant_arrive2, grant_leave2, inner_port2, outer_port2, evacuating2, pressurizing2, settling2, busy2;
    logic [CW-1:0] count2;

    int  n_cmp = 0;
    int  n_bad = 0;
    ev_t exp_q[$];
    ev_t exp2_q[$];

    airlock_sequencer #(.CW(CW), .EVAC_TICKS(8), .PRESS_TICKS(7), .SETTLE_TICKS(5)) dut (
        .clk(clk), .reset(reset), .tick(tick), .arrive_req(arrive_req), .leave_req(leave_req),
        .occupied(occupied), .hold(hold), .grant_arrive(grant_arrive), .grant_leave(grant_leave),
        .inner_port(inner_port), .outer_port(outer_port), .evacuating(evacuating),
        .pressurizing(pressurizing), .settling(settling), .busy(busy), .count(count)
    );

    airlock_sequencer #(.CW(CW), .EVAC_TICKS(8), .PRESS_TICKS(7), .SETTLE_TICKS(0)) dut_nosettle (
        .clk(clk), .reset(reset), .tick(tick), .arrive_req(arrive_req2), .leave_req(leave_req2),
        .occupied(occupied), .hold(hold), .grant_arrive(grant_arrive2), .grant_leave(grant_leave2),
        .inner_port(inner_port2), .outer_port(outer_port2), .evacuating(evacuating2),
        .pressurizing(pressurizing2), .settling(settling2), .busy(busy2), .count(count2)
    );

    always #5 clk = ~clk;

    // One tick every 4 clocks, driven just after the rising edge.
    initial begin : tick_gen
        int tc;
        tc = 0;
        forever begin
            @(posedge clk);
            #1;
            tick = (tc == 3);
            tc   = (tc + 1) % 4;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int phase_code(input logic ev, input logic op, input logic st,
                                      input logic pr, input logic ip);
        if (ev) return C_EVAC;
        if (op) return C_OUTER;
        if (st) return C_SETTLE;
        if (pr) return C_PRESS;
        if (ip) return C_INNER;
        return C_IDLE;
    endfunction

    function automatic bit is_timed(input int c);
        return (c == C_EVAC) || (c == C_PRESS) || (c == C_SETTLE);
    endfunction

    function automatic bit cond(input int sel);
        case (sel)
            0: return busy;
            1: return !busy;
            2: return outer_port;
            3: return inner_port;
            4: return evacuating && (count == CW'(4)) && !tick;
            5: return busy2;
            6: return !busy2;
            7: return inner_port2;
            8: return outer_port2;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_cond(input int sel, input string nm);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (cond(sel)) break;
            n++;
            if (n > 300) begin
                chk({"timeout_", nm}, 0, 1);
                break;
            end
        end
    endtask

    task automatic push(input int c, input int n);
        exp_q.push_back('{code: c, cnt: n});
    endtask

    task automatic push2(input int c, input int n);
        exp2_q.push_back('{code: c, cnt: n});
    endtask

    // Primary DUT monitor: invariants, grant/phase scoreboard, per-cycle countdown model.
    int prev_code = 0, exp_cnt = 0, last_cnt = 0;
    bit last_hold = 1'b0;
    always @(negedge clk) begin : mon1
        int  code;
        ev_t e;
        if (reset) begin
            prev_code = C_IDLE;
            exp_cnt   = 0;
            last_cnt  = 0;
            last_hold = 1'b0;
        end else begin
            chk("inv_doors", int'(inner_port & outer_port), 0);
            chk("inv_pump_door", int'((evacuating | pressurizing) & (inner_port | outer_port)), 0);
            chk("inv_pump_onehot", int'((int'(evacuating) + int'(pressurizing) + int'(settling)) > 1), 0);
            code = phase_code(evacuating, outer_port, settling, pressurizing, inner_port);
            chk("inv_busy", int'(busy), int'(code != C_IDLE));
            if (grant_arrive || grant_leave) begin
                if (exp_q.size() == 0) begin
                    chk("grant_unexpected", grant_leave ? C_GL : C_GA, -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant", grant_leave ? C_GL : C_GA, e.code);
                end
            end
            if (code != prev_code) begin
                if (is_timed(prev_code)) chk("exit_count", last_cnt, 0);
                if (exp_q.size() == 0) begin
                    chk("phase_unexpected", code, -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("phase", code, e.code);
                    chk("entry_count", int'(count), e.cnt);
                end
            end else if (is_timed(code)) begin
                chk("count_step", int'(count), exp_cnt);
                chk("exit_late", int'(last_cnt == 0 && !last_hold), 0);
            end else begin
                chk("untimed_count", int'(count), 0);
            end
            exp_cnt   = (is_timed(code) && tick && !hold && count != '0) ? int'(count) - 1 : int'(count);
            last_cnt  = int'(count);
            last_hold = hold;
            prev_code = code;
        end
    end

    // Monitor for the build without the settle phase.
    int prev2 = 0;
    always @(negedge clk) begin : mon2
        int  code;
        ev_t e;
        if (reset) begin
            prev2 = C_IDLE;
        end else begin
            chk("nosettle_settling", int'(settling2), 0);
            chk("nosettle_doors", int'(inner_port2 & outer_port2), 0);
            code = phase_code(evacuating2, outer_port2, settling2, pressurizing2, inner_port2);
            if (grant_arrive2 || grant_leave2) begin
                if (exp2_q.size() == 0) begin
                    chk("nosettle_grant_unexpected", grant_leave2 ? C_GL : C_GA, -1);
                end else begin
                    e = exp2_q.pop_front();
                    chk("nosettle_grant", grant_leave2 ? C_GL : C_GA, e.code);
                end
            end
            if (code != prev2) begin
                if (exp2_q.size() == 0) begin
                    chk("nosettle_phase_unexpected", code, -1);
                end else begin
                    e = exp2_q.pop_front();
                    chk("nosettle_phase", code, e.code);
                    chk("nosettle_entry_count", int'(count2), e.cnt);
                end
            end
            prev2 = code;
        end
    end

    task automatic chk_all_zero(input string nm);
        chk(nm, int'({grant_arrive, grant_leave, inner_port, outer_port, evacuating,
                      pressurizing, settling, busy, count}), 0);
    endtask

    // One full sequence; optional hold mid-EVAC or reset while the outer door is open.
    task automatic run_seq(input bit lv, input bit drive, input bit drop,
                           input bit do_hold, input bit do_reset);
        push(lv ? C_GL : C_GA, 0);
        if (!lv) begin
            push(C_EVAC, 8); push(C_OUTER, 0); push(C_SETTLE, 5);
            push(C_PRESS, 7); push(C_INNER, 0); push(C_IDLE, 0);
        end else begin
            push(C_INNER, 0); push(C_SETTLE, 5); push(C_EVAC, 8); push(C_OUTER, 0);
            push(C_SETTLE, 5); push(C_PRESS, 7); push(C_IDLE, 0);
        end
        if (drive) begin
            @(posedge clk); #1;
            if (lv) leave_req = 1'b1;
            else    arrive_req = 1'b1;
        end
        wait_cond(0, "busy");
        if (drop) begin
            @(posedge clk); #1;
            arrive_req = 1'b0;
            leave_req  = 1'b0;
        end
        if (!lv) begin
            if (do_hold) begin
                wait_cond(4, "evac_count4");
                @(posedge clk); #1;
                hold = 1'b1;
                repeat (40) @(posedge clk);
                @(negedge clk);
                chk("hold_count", int'(count), 4);
                chk("hold_evacuating", int'(evacuating), 1);
                @(posedge clk); #1;
                hold = 1'b0;
                chk("hold_release_count", int'(count), 4);
            end
            wait_cond(2, "outer_open");
            @(posedge clk); #1;
            occupied = 1'b1;
            wait_cond(3, "inner_open");
            @(posedge clk); #1;
            occupied = 1'b0;
            wait_cond(1, "idle");
        end else begin
            wait_cond(3, "inner_open");
            @(posedge clk); #1;
            occupied = 1'b1;
            wait_cond(2, "outer_open");
            if (do_reset) begin
                @(posedge clk); #1;
                reset = 1'b1;
                @(posedge clk); #1;
                chk_all_zero("reset_mid_seq");
                exp_q.delete();
                reset    = 1'b0;
                occupied = 1'b0;
            end else begin
                @(posedge clk); #1;
                occupied = 1'b0;
                wait_cond(1, "idle");
            end
        end
    endtask

    initial begin : stim
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset_state");
        reset = 1'b0;

        run_seq(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_seq(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        @(posedge clk); #1;
        arrive_req = 1'b1;
        leave_req  = 1'b1;
        run_seq(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_seq(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_seq(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        run_seq(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

        run_seq(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        run_seq(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        push2(C_GL, 0); push2(C_INNER, 0); push2(C_EVAC, 8);
        push2(C_OUTER, 0); push2(C_PRESS, 7); push2(C_IDLE, 0);
        @(posedge clk); #1;
        leave_req2 = 1'b1;
        wait_cond(5, "nosettle_busy");
        @(posedge clk); #1;
        leave_req2 = 1'b0;
        wait_cond(7, "nosettle_inner");
        @(posedge clk); #1;
        occupied = 1'b1;
        wait_cond(8, "nosettle_outer");
        @(posedge clk); #1;
        occupied = 1'b0;
        wait_cond(6, "nosettle_idle");

        repeat (5) @(negedge clk);
        chk("queue_drain", exp_q.size(), 0);
        chk("nosettle_queue_drain", exp2_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
